muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/result bundle between the core and the multiply/divide unit.
//   start, op, a, b   : operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we, wdata: MTHI / MTLO writes into the HI/LO registers
//   busy, done         : in-flight indicator and one-cycle completion pulse
//   hi, lo             : architectural HI/LO registers
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : muldiv_unit_if.slave (request, MTHI/MTLO writes, busy/done, hi/lo)
// Every operation takes the same path: start edge, 32 CALC iterations, one FIX
// edge that applies sign correction and writes hi/lo. The datapath always works
// on operand magnitudes; signs are captured at start and re-applied in FIX.
module muldiv_unit (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;        // result (product / quotient) must be negated
  logic        sign_a_q, sign_a_d;  // remainder takes the dividend's sign
  logic [31:0] mcand_q, mcand_d;    // multiplicand or divisor magnitude
  logic [31:0] work_hi_q, work_hi_d;  // product upper half, or partial remainder
  logic [31:0] work_lo_q, work_lo_d;  // multiplier/product lower half, or dividend/quotient
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Start-time operand conditioning
  logic        op_signed;
  logic        sa, sb;
  logic [31:0] mag_a, mag_b;

  // One iteration of each algorithm
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;

  // FIX-stage results
  logic [63:0] prod, prod_neg;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    op_signed = ~bus.op[0];
    sa        = op_signed & bus.a[31];
    sb        = op_signed & bus.b[31];
    mag_a     = sa ? (32'd0 - bus.a) : bus.a;
    mag_b     = sb ? (32'd0 - bus.b) : bus.b;

    // Shift-add: add multiplicand when the current multiplier bit is set,
    // then shift the 64-bit accumulator right by one (carry enters at the top).
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mcand_q} : 33'd0);

    // Restoring divide: bring in the next dividend bit, subtract if it fits.
    // The difference always fits in 32 bits when the subtraction is taken.
    div_shift = {work_hi_q, work_lo_q[31]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    div_sub   = div_shift[31:0] - mcand_q;

    prod      = {work_hi_q, work_lo_q};
    prod_neg  = 64'd0 - prod;
    // With a zero divisor every step "subtracts", leaving an all-ones quotient
    // and the dividend magnitude as remainder; only the quotient needs forcing.
    if (mcand_q == 32'd0)
      quot_fix = 32'hFFFF_FFFF;
    else
      quot_fix = neg_q ? (32'd0 - work_lo_q) : work_lo_q;
    rem_fix   = sign_a_q ? (32'd0 - work_hi_q) : work_hi_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    sign_a_d  = sign_a_q;
    mcand_d   = mcand_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          is_div_d  = bus.op[1];
          neg_d     = sa ^ sb;
          sign_a_d  = sa;
          // Multiplication is symmetric, so both algorithms load A into the
          // shifting register and B into the fixed operand register.
          mcand_d   = mag_b;
          work_hi_d = 32'd0;
          work_lo_d = mag_a;
          cnt_d     = 5'd0;
          state_d   = CALC;
        end
      end

      CALC: begin
        if (is_div_q) begin
          work_hi_d = div_ge ? div_sub : div_shift[31:0];
          work_lo_d = {work_lo_q[30:0], div_ge};
        end else begin
          work_hi_d = mul_sum[32:1];
          work_lo_d = {mul_sum[0], work_lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end

      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      mcand_q   <= 32'd0;
      work_hi_q <= 32'd0;
      work_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      sign_a_q  <= sign_a_d;
      mcand_q   <= mcand_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed, table-driven bench for muldiv_unit plus hand
// sequences for the handshake, MTHI/MTLO and reset corner cases.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Called at a negedge; returns 1ns after the start edge with garbage on the
  // operand inputs (they must not matter any more).
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Waits (bounded) for done; returns at the negedge of the done cycle.
  // inj != 0 drives a competing start plus MTHI/MTLO at that busy cycle.
  task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el,
                           input int inj);
    int          busy_cnt = 0;
    bit          got      = 1'b0;
    bit          hold_bad = 1'b0;
    logic [31:0] h0 = '0;
    logic [31:0] l0 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        h0 = bus.hi;
        l0 = bus.lo;
      end
      if (inj != 0 && k == inj) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
      end else if (inj != 0 && k == inj + 1) begin
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      end
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (bus.hi !== h0 || bus.lo !== l0) hold_bad = 1'b1;
    end
    chk({name, " done_seen"}, {31'd0, got}, 32'd1);
    chk({name, " busy_cycles"}, busy_cnt, 32'd33);
    chk({name, " hold_hilo"}, {31'd0, hold_bad}, 32'd0);
    chk({name, " busy_in_done"}, {31'd0, bus.busy}, 32'd0);
    chk({name, " hi"}, bus.hi, eh);
    chk({name, " lo"}, bus.lo, el);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5"};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
    vecs[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7d2"};
    vecs[4]  = '{2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "div_by0"};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min2"};
    vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1m1"};
    vecs[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2"};
    vecs[9]  = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, "div_m7dm2"};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_by0"};
    vecs[11] = '{2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, "div_neg_by0"};
    vecs[12] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100d7"};
    vecs[13] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu_shift"};

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // MTHI / MTLO in IDLE
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    chk("mthi hi", bus.hi, 32'hCAFE_F00D);
    chk("mthi lo_untouched", bus.lo, 32'd0);
    @(negedge clk);
    bus.lo_we = 1'b1; bus.wdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    chk("mtlo lo", bus.lo, 32'h1111_2222);
    chk("mtlo hi_untouched", bus.hi, 32'hCAFE_F00D);

    // Table of operations
    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, 0);
      @(negedge clk);
      chk({vecs[i].name, " done_single"}, {31'd0, bus.done}, 32'd0);
    end

    // MTHI together with start: write lands now, result overwrites later
    bus.hi_we = 1'b1; bus.wdata = 32'h5555_5555;
    start_op(2'b01, 32'd2, 32'd3);
    bus.hi_we = 1'b0;
    chk("mthi_with_start hi", bus.hi, 32'h5555_5555);
    wait_done("mthi_with_start", 32'd0, 32'd6, 0);
    @(negedge clk);

    // Competing start and MTHI/MTLO while busy are ignored
    start_op(2'b01, 32'd6, 32'd7);
    wait_done("ignore_busy", 32'd0, 32'd42, 10);
    @(negedge clk);
    chk("ignore_busy no_queue", {31'd0, bus.busy}, 32'd0);

    // Start in the done cycle is accepted
    start_op(2'b11, 32'd100, 32'd7);
    wait_done("first_of_pair", 32'd2, 32'd14, 0);
    start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("done_cycle_start busy", {31'd0, bus.busy}, 32'd1);
    chk("done_cycle_start done", {31'd0, bus.done}, 32'd0);
    wait_done("second_of_pair", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    @(negedge clk);

    // Reset mid-operation
    begin
      bit seen_done = 1'b0;
      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (14) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst hi", bus.hi, 32'd0);
      chk("midrst lo", bus.lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (bus.done) seen_done = 1'b1;
      end
      chk("midrst no_done", {31'd0, seen_done}, 32'd0);
    end

    // First start after reset behaves normally
    start_op(2'b01, 32'd3, 32'd4);
    wait_done("after_rst", 32'd0, 32'd12, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
